// File: rtl/dcr_pkg.sv
// Shared definitions for the device control register bank: register map,
// CONTROL/STATUS bit positions and launch FSM states.
package dcr_pkg;

  localparam int unsigned ADDR_THREAD_COUNT = 32'd0;
  localparam int unsigned ADDR_CONTROL      = 32'd1;
  localparam int unsigned ADDR_STATUS       = 32'd2;
  localparam int unsigned ADDR_CONFIG_BASE  = 32'd3;

  localparam int unsigned CTRL_START      = 32'd0;
  localparam int unsigned CTRL_CLEAR_DONE = 32'd1;
  localparam int unsigned CTRL_CLEAR_ERR  = 32'd2;

  localparam int unsigned STAT_BUSY = 32'd0;
  localparam int unsigned STAT_DONE = 32'd1;
  localparam int unsigned STAT_ERR  = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } dcr_state_t;

  function automatic logic [2:0] pack_status(input logic busy, input logic done, input logic err);
    logic [2:0] s;
    s = 3'b000;
    s[STAT_BUSY] = busy;
    s[STAT_DONE] = done;
    s[STAT_ERR]  = err;
    return s;
  endfunction

endpackage

// File: rtl/dcr_launch_fsm.sv
// Kernel launch sequencer: IDLE -> LAUNCH (one-cycle kernel_start) -> RUN,
// plus the sticky done/err flags that the sequencer owns.
module dcr_launch_fsm
  import dcr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_thread_zero,
  input  logic i_clear_done,
  input  logic i_clear_err,
  input  logic i_err_set,
  input  logic i_kernel_done,
  output logic o_kernel_start,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  dcr_state_t r_state;
  logic       r_kernel_start;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  // State sequencing with registered busy/kernel_start and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_kernel_start <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_kernel_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_thread_zero) begin
            r_state        <= ST_LAUNCH;
            r_kernel_start <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_kernel_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // An accepted START overrides CLEAR_DONE; zero threads completes at once
      if ((r_state == ST_IDLE) && i_start) begin
        r_done <= i_thread_zero;
      end else if ((r_state == ST_RUN) && i_kernel_done) begin
        r_done <= 1'b1;
      end else if (i_clear_done) begin
        r_done <= 1'b0;
      end

      if (i_err_set) begin
        r_err <= 1'b1;
      end else if (i_clear_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_kernel_start = r_kernel_start;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: rtl/dcr_bank.sv
// Device control register bank: thread count, CONTROL/STATUS and config
// registers with a one-cycle registered read path, driving the launch FSM.
module dcr_bank
  import dcr_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 6,
  parameter int ADDR_BITS = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              device_control_write_enable,
  input  logic [ADDR_BITS-1:0]              device_control_address,
  input  logic [DATA_BITS-1:0]              device_control_data,
  input  logic                              device_control_read_enable,
  output logic [DATA_BITS-1:0]              device_control_read_data,
  output logic                              device_control_read_valid,
  output logic [DATA_BITS-1:0]              thread_count,
  output logic [(NUM_REGS-3)*DATA_BITS-1:0] config_regs,
  output logic                              kernel_start,
  input  logic                              kernel_done,
  output logic                              busy,
  output logic                              done
);

  logic [DATA_BITS-1:0]              r_thread_count;
  logic [(NUM_REGS-3)*DATA_BITS-1:0] r_config;
  logic [DATA_BITS-1:0]              r_read_data;
  logic                              r_read_valid;

  logic [31:0]          w_addr;
  logic                 w_is_tc;
  logic                 w_is_ctrl;
  logic                 w_is_cfg;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_err;
  logic                 w_ctrl_wr;
  logic                 w_start;
  logic                 w_clear_done;
  logic                 w_clear_err;
  logic                 w_err_set;
  logic                 w_wr_accept;
  logic [DATA_BITS-1:0] w_read_mux;

  assign w_addr    = {{(32-ADDR_BITS){1'b0}}, device_control_address};
  assign w_is_tc   = (w_addr == ADDR_THREAD_COUNT);
  assign w_is_ctrl = (w_addr == ADDR_CONTROL);
  assign w_is_cfg  = (w_addr >= ADDR_CONFIG_BASE) && (w_addr < NUM_REGS);

  assign w_ctrl_wr    = device_control_write_enable && w_is_ctrl;
  assign w_start      = w_ctrl_wr && device_control_data[CTRL_START];
  assign w_clear_done = w_ctrl_wr && device_control_data[CTRL_CLEAR_DONE];
  assign w_clear_err  = w_ctrl_wr && device_control_data[CTRL_CLEAR_ERR];
  assign w_wr_accept  = device_control_write_enable && !w_busy;
  // Out-of-range and STATUS writes never reach this term, so they cannot raise err
  assign w_err_set    = device_control_write_enable && w_busy &&
                        (w_is_tc || w_is_cfg || w_start);

  // Read mux samples register state before any same-edge write lands
  always_comb begin
    w_read_mux = '0;
    if (w_is_tc) begin
      w_read_mux = r_thread_count;
    end else if (w_addr == ADDR_STATUS) begin
      w_read_mux[2:0] = pack_status(w_busy, w_done, w_err);
    end else if (w_is_cfg) begin
      for (int i = 0; i < NUM_REGS - 3; i++) begin
        if (w_addr == (ADDR_CONFIG_BASE + i)) begin
          w_read_mux = r_config[i*DATA_BITS +: DATA_BITS];
        end
      end
    end else begin
      w_read_mux = '0;
    end
  end

  // Register file writes and registered read response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_thread_count <= '0;
      r_config       <= '0;
      r_read_data    <= '0;
      r_read_valid   <= 1'b0;
    end else begin
      if (w_wr_accept && w_is_tc) begin
        r_thread_count <= device_control_data;
      end
      for (int i = 0; i < NUM_REGS - 3; i++) begin
        if (w_wr_accept && (w_addr == (ADDR_CONFIG_BASE + i))) begin
          r_config[i*DATA_BITS +: DATA_BITS] <= device_control_data;
        end
      end
      r_read_valid <= device_control_read_enable;
      if (device_control_read_enable) begin
        r_read_data <= w_read_mux;
      end
    end
  end

  dcr_launch_fsm u_fsm (
    .clk            (clk),
    .reset          (reset),
    .i_start        (w_start),
    .i_thread_zero  (r_thread_count == '0),
    .i_clear_done   (w_clear_done),
    .i_clear_err    (w_clear_err),
    .i_err_set      (w_err_set),
    .i_kernel_done  (kernel_done),
    .o_kernel_start (kernel_start),
    .o_busy         (w_busy),
    .o_done         (w_done),
    .o_err          (w_err)
  );

  assign busy                      = w_busy;
  assign done                      = w_done;
  assign thread_count              = r_thread_count;
  assign config_regs               = r_config;
  assign device_control_read_data  = r_read_data;
  assign device_control_read_valid = r_read_valid;

endmodule

// File: tb/tb_dcr_bank.sv
// Directed, table-driven bench for dcr_bank with default parameters,
// plus hand-written launch/complete and reset-in-RUN sequences.
module tb_dcr_bank;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic        re;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [7:0]  tc;
  logic [23:0] cfg;
  logic        kstart;
  logic        kdone;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  dcr_bank #(.DATA_BITS(8), .NUM_REGS(6), .ADDR_BITS(3)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .device_control_write_enable (we),
    .device_control_address      (addr),
    .device_control_data         (wdata),
    .device_control_read_enable  (re),
    .device_control_read_data    (rdata),
    .device_control_read_valid   (rvalid),
    .thread_count                (tc),
    .config_regs                 (cfg),
    .kernel_start                (kstart),
    .kernel_done                 (kdone),
    .busy                        (busy),
    .done                        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic        kd;
    logic        rv;
    logic [7:0]  rd;
    logic [7:0]  tc;
    logic [23:0] cfg;
    logic        ks;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_i, input logic we_i, input logic re_i,
                              input logic [2:0] a_i, input logic [7:0] d_i, input logic kd_i,
                              input logic rv_i, input logic [7:0] rd_i, input logic [7:0] tc_i,
                              input logic [23:0] cfg_i, input logic ks_i, input logic b_i,
                              input logic dn_i);
    vec_t v;
    v.rst = rst_i; v.we = we_i; v.re = re_i; v.addr = a_i; v.data = d_i; v.kd = kd_i;
    v.rv = rv_i; v.rd = rd_i; v.tc = tc_i; v.cfg = cfg_i; v.ks = ks_i; v.busy = b_i; v.done = dn_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic rst_i, input logic we_i, input logic re_i,
                      input logic [2:0] a_i, input logic [7:0] d_i, input logic kd_i);
    reset = rst_i; we = we_i; re = re_i; addr = a_i; wdata = d_i; kdone = kd_i;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 8'h00; kdone = 1'b0;

    //            rst  we   re   addr  data   kd    rv   rd     tc     cfg         ks   busy done
    vecs.push_back(mk(1'b1,1'b1,1'b1,3'd0,8'h55,1'b1, 1'b0,8'h00,8'h00,24'h000000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd0,8'h20,1'b0, 1'b0,8'h00,8'h20,24'h000000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd4,8'hA5,1'b0, 1'b0,8'h00,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd0,8'h00,1'b0, 1'b1,8'h20,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd4,8'h00,1'b0, 1'b1,8'hA5,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'd0,8'h00,1'b0, 1'b0,8'hA5,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd7,8'hFF,1'b0, 1'b0,8'hA5,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd7,8'h00,1'b0, 1'b1,8'h00,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd4,8'h00,1'b0, 1'b1,8'hA5,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd1,8'h00,1'b0, 1'b1,8'h00,8'h20,24'h00A500,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,3'd3,8'h3C,1'b0, 1'b1,8'h00,8'h20,24'h00A53C,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd3,8'h00,1'b0, 1'b1,8'h3C,8'h20,24'h00A53C,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'd0,8'h00,1'b1, 1'b0,8'h3C,8'h20,24'h00A53C,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd0,8'h08,1'b0, 1'b0,8'h3C,8'h08,24'h00A53C,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd1,8'h01,1'b0, 1'b0,8'h3C,8'h08,24'h00A53C,1'b1,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'd0,8'h00,1'b1, 1'b0,8'h3C,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'd0,8'h00,1'b0, 1'b0,8'h3C,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd0,8'h10,1'b0, 1'b0,8'h3C,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd5,8'h77,1'b0, 1'b0,8'h3C,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd1,8'h01,1'b0, 1'b0,8'h3C,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd2,8'h00,1'b0, 1'b1,8'h05,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd1,8'h04,1'b0, 1'b0,8'h05,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd2,8'h00,1'b0, 1'b1,8'h01,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd1,8'h05,1'b0, 1'b0,8'h01,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd2,8'h00,1'b0, 1'b1,8'h05,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd1,8'h04,1'b0, 1'b0,8'h05,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd2,8'h00,1'b0, 1'b1,8'h01,8'h08,24'h00A53C,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'd0,8'h00,1'b1, 1'b0,8'h01,8'h08,24'h00A53C,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b1,3'd2,8'h00,1'b0, 1'b1,8'h02,8'h08,24'h00A53C,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd1,8'h02,1'b0, 1'b0,8'h02,8'h08,24'h00A53C,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd0,8'h00,1'b0, 1'b0,8'h02,8'h00,24'h00A53C,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,3'd1,8'h01,1'b0, 1'b0,8'h02,8'h00,24'h00A53C,1'b0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,3'd0,8'h00,1'b0, 1'b0,8'h02,8'h00,24'h00A53C,1'b0,1'b0,1'b1));

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].data, vecs[i].kd);
      chk($sformatf("row%0d read_valid", i), {31'd0, rvalid}, {31'd0, vecs[i].rv});
      chk($sformatf("row%0d read_data", i), {24'd0, rdata}, {24'd0, vecs[i].rd});
      chk($sformatf("row%0d thread_count", i), {24'd0, tc}, {24'd0, vecs[i].tc});
      chk($sformatf("row%0d config_regs", i), {8'd0, cfg}, {8'd0, vecs[i].cfg});
      chk($sformatf("row%0d kernel_start", i), {31'd0, kstart}, {31'd0, vecs[i].ks});
      chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, vecs[i].done});
    end

    // Launch, let the kernel run, complete five cycles after the START write
    step(1'b0, 1'b1, 1'b0, 3'd0, 8'h08, 1'b0);
    chk("seqA thread_count", {24'd0, tc}, 32'h08);
    step(1'b0, 1'b1, 1'b0, 3'd1, 8'h01, 1'b0);
    chk("seqA kernel_start", {31'd0, kstart}, 32'd1);
    chk("seqA busy", {31'd0, busy}, 32'd1);
    chk("seqA done cleared", {31'd0, done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("seqA wait%0d kernel_start", k), {31'd0, kstart}, 32'd0);
      chk($sformatf("seqA wait%0d busy", k), {31'd0, busy}, 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("seqA busy after done", {31'd0, busy}, 32'd0);
    chk("seqA done", {31'd0, done}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    chk("seqA status valid", {31'd0, rvalid}, 32'd1);
    chk("seqA status", {24'd0, rdata}, 32'h02);

    // Reset while RUN aborts everything; a kernel_done right after is ignored
    step(1'b0, 1'b1, 1'b0, 3'd1, 8'h01, 1'b0);
    chk("seqB kernel_start", {31'd0, kstart}, 32'd1);
    idle();
    chk("seqB busy in run", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 3'd0, 8'h33, 1'b0);
    chk("seqB rst thread_count", {24'd0, tc}, 32'h00);
    chk("seqB rst config_regs", {8'd0, cfg}, 32'h0);
    chk("seqB rst read_valid", {31'd0, rvalid}, 32'd0);
    chk("seqB rst read_data", {24'd0, rdata}, 32'h00);
    chk("seqB rst kernel_start", {31'd0, kstart}, 32'd0);
    chk("seqB rst busy", {31'd0, busy}, 32'd0);
    chk("seqB rst done", {31'd0, done}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("seqB post kd done", {31'd0, done}, 32'd0);
    chk("seqB post kd busy", {31'd0, busy}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b0);
    chk("seqB status valid", {31'd0, rvalid}, 32'd1);
    chk("seqB status", {24'd0, rdata}, 32'h00);
    chk("seqB done idle", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcr_bank.md
DCR_BANK -- requirements
Module: dcr_bank

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the width of each register and of the data bus.
REQ-002 The block SHALL have parameter NUM_REGS, default 6 (minimum 4), meaning the number of addressable registers.
REQ-003 The block SHALL have parameter ADDR_BITS, default 3, meaning the address width; 2**ADDR_BITS >= NUM_REGS.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; one clock, all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- device_control_write_enable  in  1  write strobe.
- device_control_address  in  ADDR_BITS  register address for read and write.
- device_control_data  in  DATA_BITS  write data.
- device_control_read_enable  in  1  read strobe.
- device_control_read_data  out  DATA_BITS  registered read data.
- device_control_read_valid  out  1  read data valid pulse.
- thread_count  out  DATA_BITS  value of register 0.
- config_regs  out  (NUM_REGS-3)*DATA_BITS  registers 3..NUM_REGS-1, flattened, register 3 in the LSBs.
- kernel_start  out  1  one-cycle launch pulse.
- kernel_done  in  1  completion pulse from the dispatcher.
- busy  out  1  kernel in flight.
- done  out  1  sticky completion flag.

Function
REQ-005 The register map SHALL be: 0 THREAD_COUNT (rw); 1 CONTROL (write-only, bit0 START, bit1 CLEAR_DONE, bit2 CLEAR_ERR; reads as 0); 2 STATUS (ro, bit0 busy, bit1 done, bit2 err, other bits 0); 3..NUM_REGS-1 CONFIG (rw).
REQ-006 Writes SHALL take effect on the clock edge where device_control_write_enable is high; new values are visible on outputs the following cycle.
REQ-007 Writes to addresses >= NUM_REGS and to STATUS SHALL be ignored with no side effects; reads of those addresses SHALL return 0.
REQ-008 A read SHALL have 1-cycle latency: read_valid is high exactly one cycle after a read_enable cycle, and read_data holds the value sampled at the read_enable edge.
REQ-009 A simultaneous read and write to the same address SHALL return the pre-write value.
REQ-010 read_data SHALL hold its last value when read_valid is low.
REQ-011 The FSM SHALL have 3 states: IDLE, LAUNCH and RUN.
REQ-012 In IDLE, a CONTROL write with START=1 SHALL clear done and, when thread_count != 0, go to LAUNCH.
REQ-013 In IDLE, a START with thread_count == 0 SHALL set done, stay in IDLE and produce no kernel_start.
REQ-014 LAUNCH SHALL last exactly one cycle, assert kernel_start for that cycle, and go to RUN.
REQ-015 busy SHALL equal (state != IDLE).
REQ-016 RUN SHALL go to IDLE and set done on the cycle after kernel_done is sampled high.
REQ-017 kernel_done SHALL be ignored outside RUN, including in the LAUNCH cycle.
REQ-018 While busy, writes to THREAD_COUNT or CONFIG and writes with START=1 SHALL be rejected (register unchanged) and SHALL set err.
REQ-019 While busy, CLEAR_DONE and CLEAR_ERR SHALL still be honoured.
REQ-020 Within one CONTROL write, clear bits SHALL apply before START is evaluated, and an err set by the same write SHALL win over CLEAR_ERR.
REQ-021 err and done SHALL be sticky until cleared by CLEAR_ERR/CLEAR_DONE, by a new accepted START (done only), or by reset.

Reset
REQ-022 While reset is high, all registers, err, done, busy, kernel_start, read_valid and read_data SHALL be 0, and the FSM SHALL be in IDLE.
REQ-023 Reset asserted mid-LAUNCH or mid-RUN SHALL abort to IDLE, and a kernel_done arriving in the first cycle after reset SHALL be ignored.
REQ-024 Strobes asserted during reset SHALL have no effect.

Structure
REQ-025 A shared package dcr_pkg SHALL hold the register address constants, the CONTROL/STATUS bit indices and the FSM state enum.
REQ-026 The launch FSM SHALL be the single sub-module dcr_launch_fsm; the register file, decode and read path SHALL stay in dcr_bank.

Verification
REQ-027 The bench SHALL cover basic read/write: write 0x20 to addr 0 and 0xA5 to addr 4, then read both -> thread_count=0x20, config_regs[15:8]=0xA5, read_data 0x20 then 0xA5, each with a 1-cycle read_valid.
REQ-028 The bench SHALL cover a normal launch: thread_count=8, write CONTROL=0x01 -> kernel_start high for exactly 1 cycle the cycle after the write; busy=1; pulse kernel_done 5 cycles later -> busy=0 and done=1 next cycle; STATUS reads 0x02.
REQ-029 The bench SHALL cover rejection while busy: during RUN, write 0x10 to addr 0 and START=1 -> thread_count stays 8, no second kernel_start, STATUS reads 0x05; then CLEAR_ERR -> STATUS reads 0x01.
REQ-030 The bench SHALL cover zero threads: thread_count=0, START -> no kernel_start, busy stays 0, done=1 next cycle.
REQ-031 The bench SHALL cover boundaries: write to addr 7 with NUM_REGS=6 -> no state change and readback 0; kernel_done pulsed in IDLE and in the LAUNCH cycle -> ignored.
REQ-032 The bench SHALL cover reset mid-operation: reset in RUN -> next cycle all outputs 0 and IDLE; kernel_done right after reset -> done stays 0.
